// File: rtl/float_stream_sorter_if.sv
// Stream bundle for float_stream_sorter: upstream words in, sorted words out, frame error flag.
// The master side is the producer/consumer pair, the slave side is the sorter.
interface float_stream_sorter_if #(
    parameter int FLEN = 64
);
    logic            up_valid;
    logic            up_ready;
    logic [FLEN-1:0] up_data;
    logic            down_valid;
    logic            down_ready;
    logic [FLEN-1:0] down_data;
    logic            err;

    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data, err
    );

    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data, err
    );
endinterface

// File: rtl/float_stream_sorter.sv
// Area-lean frame sorter: load DEPTH floats, bubble-sort with one shared comparator, drain ascending.
// Build option SORT_DESCENDING_EN reverses comparator operands for non-increasing output.

// IEEE-754 a <= b. Unordered (any NaN) gives res=0 and err=1; -0 and +0 compare equal.
module f_less_or_equal #(
    parameter int FLEN = 64
) (
    input  logic [FLEN-1:0] i_a,
    input  logic [FLEN-1:0] i_b,
    output logic            o_res,
    output logic            o_err
);
    localparam int EXP_W = (FLEN == 16) ? 5 : (FLEN == 32) ? 8 : 11;
    localparam int MAN_W = FLEN - 1 - EXP_W;

    logic w_a_nan;
    logic w_b_nan;
    logic w_both_zero;
    logic w_mag_le;
    logic w_mag_ge;

    assign w_a_nan     = (&i_a[FLEN-2 -: EXP_W]) && (|i_a[MAN_W-1:0]);
    assign w_b_nan     = (&i_b[FLEN-2 -: EXP_W]) && (|i_b[MAN_W-1:0]);
    assign w_both_zero = ~(|i_a[FLEN-2:0]) && ~(|i_b[FLEN-2:0]);
    assign w_mag_le    = (i_a[FLEN-2:0] <= i_b[FLEN-2:0]);
    assign w_mag_ge    = (i_a[FLEN-2:0] >= i_b[FLEN-2:0]);

    always_comb begin
        o_res = 1'b0;
        o_err = 1'b0;
        if (w_a_nan || w_b_nan) begin
            o_err = 1'b1;
        end else if (w_both_zero) begin
            o_res = 1'b1;
        end else begin
            // Sign-magnitude: the exponent/mantissa field orders like an unsigned integer.
            case ({i_a[FLEN-1], i_b[FLEN-1]})
                2'b00:   o_res = w_mag_le;
                2'b11:   o_res = w_mag_ge;
                2'b10:   o_res = 1'b1;
                default: o_res = 1'b0;
            endcase
        end
    end
endmodule

module float_stream_sorter #(
    parameter int DEPTH = 4,
    parameter int FLEN  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    float_stream_sorter_if.slave  sorter_if
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] LAST_CMP = PTR_W'(DEPTH - 2);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SORT,
        ST_DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [FLEN-1:0]  r_buf [DEPTH];
    logic [FLEN-1:0]  w_buf_next [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_cmp_idx;
    logic [PTR_W-1:0] r_pass_cnt;
    logic             r_swapped;
    logic             r_err;

    logic [PTR_W-1:0] w_cmp_idx_hi;
    logic [FLEN-1:0]  w_lo;
    logic [FLEN-1:0]  w_hi;
    logic [FLEN-1:0]  w_cmp_a;
    logic [FLEN-1:0]  w_cmp_b;
    logic             w_res;
    logic             w_cmp_err;
    logic             w_swap;
    logic             w_pass_end;
    logic             w_up_ready;
    logic             w_down_valid;
    logic             w_up_xfer;
    logic             w_down_xfer;

    assign w_cmp_idx_hi = r_cmp_idx + PTR_W'(1);
    assign w_lo         = r_buf[r_cmp_idx];
    assign w_hi         = r_buf[w_cmp_idx_hi];

`ifdef SORT_DESCENDING_EN
    assign w_cmp_a = w_hi;
    assign w_cmp_b = w_lo;
`else
    assign w_cmp_a = w_lo;
    assign w_cmp_b = w_hi;
`endif

    f_less_or_equal #(.FLEN(FLEN)) u_cmp (
        .i_a   (w_cmp_a),
        .i_b   (w_cmp_b),
        .o_res (w_res),
        .o_err (w_cmp_err)
    );

    // Swap only on strict disorder so equal keys keep their arrival order.
    assign w_swap      = (r_state == ST_SORT) && !w_res;
    assign w_pass_end  = (r_cmp_idx == LAST_CMP);
    assign w_up_xfer   = w_up_ready && sorter_if.up_valid;
    assign w_down_xfer = w_down_valid && sorter_if.down_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_up_ready   = 1'b0;
        w_down_valid = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_up_ready = 1'b1;
                if (sorter_if.up_valid && (r_wr_ptr == LAST_IDX)) begin
                    w_state_next = ST_SORT;
                end
            end
            ST_SORT: begin
                if (w_pass_end && (!(r_swapped || w_swap) || (r_pass_cnt == LAST_CMP))) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_down_valid = 1'b1;
                if (sorter_if.down_ready && (r_rd_ptr == LAST_IDX)) begin
                    w_state_next = ST_LOAD;
                end
            end
            default: w_state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cmp_idx  <= '0;
            r_pass_cnt <= '0;
            r_swapped  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_up_xfer) begin
                        r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + PTR_W'(1);
                        if (r_wr_ptr == '0) begin
                            r_err <= 1'b0;
                        end
                    end
                end
                ST_SORT: begin
                    r_err <= r_err | w_cmp_err;
                    if (w_pass_end) begin
                        r_cmp_idx  <= '0;
                        r_swapped  <= 1'b0;
                        r_pass_cnt <= (w_state_next == ST_DRAIN) ? '0 : r_pass_cnt + PTR_W'(1);
                    end else begin
                        r_cmp_idx <= w_cmp_idx_hi;
                        r_swapped <= r_swapped | w_swap;
                    end
                end
                ST_DRAIN: begin
                    if (w_down_xfer) begin
                        r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Each slot either takes the incoming word, its swap partner, or keeps its value.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign w_buf_next[gi] =
            (w_up_xfer && (r_wr_ptr == PTR_W'(gi)))      ? sorter_if.up_data :
            (w_swap    && (r_cmp_idx == PTR_W'(gi)))     ? w_hi :
            (w_swap    && (w_cmp_idx_hi == PTR_W'(gi)))  ? w_lo :
                                                           r_buf[gi];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_buf[i] <= w_buf_next[i];
        end
    end

    assign sorter_if.up_ready   = w_up_ready;
    assign sorter_if.down_valid = w_down_valid;
    assign sorter_if.down_data  = r_buf[r_rd_ptr];
    assign sorter_if.err        = r_err;
endmodule
